// File: rtl/pipe_sequencer.sv
// rtl/pipe_sequencer.sv - boot mode machine, stage sequencer, pc and pipeline update enables (optional counters: PIPE_SEQ_PERF_EN)
module pipe_sequencer #(
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter logic [4:0]  MAX_WAIT = 5'd31
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        aa_recieved,
    input  logic        load_done,
    input  logic        aa_sent,
    input  logic [31:0] d_npc,
    input  logic        d_hazard,
    input  logic [4:0]  de_wait_time,
    input  logic        de_stop,
    input  logic        uart_busy,
    output logic [2:0]  mode,
    output logic [2:0]  pipe,
    output logic [31:0] pc,
    output logic [1:0]  fd_update,
    output logic [1:0]  de_update,
    output logic [1:0]  ew_update,
    output logic        e_start,
    output logic        halted,
    output logic [31:0] retired,
    output logic [31:0] exec_cycles
);

    typedef enum logic [2:0] {
        M_STALL = 3'd0,
        M_LOAD  = 3'd1,
        M_EXEC  = 3'd2,
        M_HALT  = 3'd3
    } mode_t;

    typedef enum logic [2:0] {
        P_FETCH    = 3'd0,
        P_DECODE   = 3'd1,
        P_EXECUTE  = 3'd2,
        P_WRITEREG = 3'd3,
        P_STOP     = 3'd4
    } pipe_t;

    mode_t       r_mode,      w_mode_nxt;
    pipe_t       r_pipe,      w_pipe_nxt;
    logic [31:0] r_pc,        w_pc_nxt;
    logic [4:0]  r_latency,   w_latency_nxt;
    logic        r_e_start,   w_e_start_nxt;
    logic        r_halted,    w_halted_nxt;
    logic        r_load_flag, w_load_flag_nxt;
    logic        r_sent_flag, w_sent_flag_nxt;

    logic [4:0]  w_wait;
    logic        w_load_seen;
    logic        w_sent_seen;
    logic        w_in_exec;

    // Effective execute latency, clamped so a bad decode cannot stall the core forever
    assign w_wait      = (de_wait_time > MAX_WAIT) ? MAX_WAIT : de_wait_time;
    assign w_load_seen = r_load_flag | load_done;
    assign w_sent_seen = r_sent_flag | aa_sent;
    assign w_in_exec   = (r_mode == M_EXEC);

    // State register for mode/stage machines and their datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode      <= M_STALL;
            r_pipe      <= P_FETCH;
            r_pc        <= PC_RESET;
            r_latency   <= 5'd0;
            r_e_start   <= 1'b0;
            r_halted    <= 1'b0;
            r_load_flag <= 1'b0;
            r_sent_flag <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_pipe      <= w_pipe_nxt;
            r_pc        <= w_pc_nxt;
            r_latency   <= w_latency_nxt;
            r_e_start   <= w_e_start_nxt;
            r_halted    <= w_halted_nxt;
            r_load_flag <= w_load_flag_nxt;
            r_sent_flag <= w_sent_flag_nxt;
        end
    end

    // Next-state logic: boot handshake, then per-instruction stage walk
    always_comb begin
        w_mode_nxt      = r_mode;
        w_pipe_nxt      = r_pipe;
        w_pc_nxt        = r_pc;
        w_latency_nxt   = r_latency;
        w_e_start_nxt   = r_e_start;
        w_halted_nxt    = r_halted;
        w_load_flag_nxt = r_load_flag;
        w_sent_flag_nxt = r_sent_flag;
        case (r_mode)
            M_STALL: begin
                if (aa_recieved) w_mode_nxt = M_LOAD;
            end
            M_LOAD: begin
                // Either event may arrive first; remember it until the other shows up
                if (w_load_seen && w_sent_seen) begin
                    w_mode_nxt      = M_EXEC;
                    w_load_flag_nxt = 1'b0;
                    w_sent_flag_nxt = 1'b0;
                end else begin
                    w_load_flag_nxt = w_load_seen;
                    w_sent_flag_nxt = w_sent_seen;
                end
            end
            M_EXEC: begin
                case (r_pipe)
                    P_FETCH: w_pipe_nxt = P_DECODE;
                    P_DECODE: begin
                        if (!d_hazard) begin
                            w_pipe_nxt    = P_EXECUTE;
                            w_pc_nxt      = d_npc;
                            w_e_start_nxt = 1'b1;
                            w_latency_nxt = 5'd0;
                        end
                    end
                    P_EXECUTE: begin
                        // e_start is a single-cycle strobe marking the first execute cycle
                        w_e_start_nxt = 1'b0;
                        if (r_latency < w_wait) begin
                            w_latency_nxt = r_latency + 5'd1;
                        end else if (!uart_busy) begin
                            w_pipe_nxt    = P_WRITEREG;
                            w_latency_nxt = 5'd0;
                        end
                    end
                    P_WRITEREG: begin
                        if (de_stop) begin
                            w_pipe_nxt   = P_STOP;
                            w_mode_nxt   = M_HALT;
                            w_halted_nxt = 1'b1;
                        end else begin
                            w_pipe_nxt = P_FETCH;
                        end
                    end
                    default: w_pipe_nxt = r_pipe;
                endcase
            end
            default: begin
                w_mode_nxt = r_mode;
            end
        endcase
    end

    assign fd_update = (w_in_exec && r_pipe == P_FETCH)                ? 2'b01 : 2'b00;
    assign de_update = (w_in_exec && r_pipe == P_DECODE && !d_hazard)  ? 2'b01 : 2'b00;
    assign ew_update = (w_in_exec && r_pipe == P_WRITEREG)             ? 2'b01 : 2'b00;

    assign mode    = r_mode;
    assign pipe    = r_pipe;
    assign pc      = r_pc;
    assign e_start = r_e_start;
    assign halted  = r_halted;

`ifdef PIPE_SEQ_PERF_EN
    logic [31:0] r_retired;
    logic [31:0] r_exec_cycles;

    // Retirement and EXEC-residency counters, free-running modulo 2^32
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_retired     <= 32'd0;
            r_exec_cycles <= 32'd0;
        end else begin
            if (w_in_exec && r_pipe == P_WRITEREG) r_retired <= r_retired + 32'd1;
            if (w_in_exec) r_exec_cycles <= r_exec_cycles + 32'd1;
        end
    end

    assign retired     = r_retired;
    assign exec_cycles = r_exec_cycles;
`else
    assign retired     = 32'd0;
    assign exec_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb/tb_pipe_sequencer.sv - scoreboard bench for pipe_sequencer
module tb_pipe_sequencer;

    localparam logic [31:0] PC_RST = 32'h0000_0040;
    localparam int          MAXW   = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        aa_recieved, load_done, aa_sent;
    logic [31:0] d_npc;
    logic        d_hazard;
    logic [4:0]  de_wait_time;
    logic        de_stop, uart_busy;
    logic [2:0]  mode, pipe;
    logic [31:0] pc;
    logic [1:0]  fd_update, de_update, ew_update;
    logic        e_start, halted;
    logic [31:0] retired, exec_cycles;

    pipe_sequencer #(.PC_RESET(PC_RST), .MAX_WAIT(5'd8)) dut (
        .clk(clk), .rstn(rstn), .aa_recieved(aa_recieved), .load_done(load_done),
        .aa_sent(aa_sent), .d_npc(d_npc), .d_hazard(d_hazard), .de_wait_time(de_wait_time),
        .de_stop(de_stop), .uart_busy(uart_busy), .mode(mode), .pipe(pipe), .pc(pc),
        .fd_update(fd_update), .de_update(de_update), .ew_update(ew_update),
        .e_start(e_start), .halted(halted), .retired(retired), .exec_cycles(exec_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_ret;
    int   sum_cyc;
    logic [31:0] last_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] perf(input int v);
`ifdef PIPE_SEQ_PERF_EN
        return v;
`else
        return (v == v) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Monitor: measure each instruction from its FETCH cycle to its WRITEREG cycle
    int  m_cyc, m_es, m_du;
    bit  m_trk = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_trk = 1'b0;
            end else if (mode == 3'd2) begin
                if (fd_update == 2'b01) begin
                    m_trk = 1'b1; m_cyc = 0; m_es = 0; m_du = 0;
                end
                if (m_trk) begin
                    m_cyc++;
                    if (e_start) m_es++;
                    if (de_update == 2'b01) m_du++;
                    if (ew_update == 2'b01) begin
                        if (q.size() == 0) begin
                            chk("unexpected_retire", 32'd1, 32'd0);
                        end else begin
                            e = q.pop_front();
                            chk("period", m_cyc, e.cyc);
                            chk("pc", pc, e.pc);
                            chk("e_start_cnt", m_es, 1);
                            chk("de_update_cnt", m_du, 1);
                        end
                        m_trk = 1'b0;
                    end
                end
            end
        end
    end

    task automatic boot();
        chk("boot_stall", mode, 3'd0);
        aa_recieved = 1'b1;
        @(negedge clk); aa_recieved = 1'b0;
        chk("boot_load", mode, 3'd1);
        aa_sent = 1'b1;
        @(negedge clk); aa_sent = 1'b0;
        repeat (2) @(negedge clk);
        chk("boot_wait_load_done", mode, 3'd1);
        load_done = 1'b1;
        @(negedge clk); load_done = 1'b0;
        chk("boot_exec", mode, 3'd2);
        chk("boot_pipe_fetch", pipe, 3'd0);
    endtask

    task automatic wait_decode(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (mode == 3'd2 && pipe == 3'd1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("decode_timeout", 32'd1, 32'd0);
    endtask

    // Drive one instruction: h hazard cycles in DECODE, u busy cycles once latency reaches W
    task automatic run_instr(input int w, input int h, input int u, input bit stop,
                             input bit seq_pc);
        bit   ok;
        int   weff;
        exp_t e;
        wait_decode(ok);
        if (!ok) return;
        weff = (w > MAXW) ? MAXW : w;
        last_pc = seq_pc ? last_pc + 32'd1 : $urandom;
        d_npc = last_pc;
        de_wait_time = w[4:0];
        de_stop = stop;
        e.pc = last_pc;
        e.cyc = 4 + weff + h + u;
        q.push_back(e);
        n_ret++;
        sum_cyc += e.cyc;
        d_hazard = (h > 0);
        repeat (h) @(negedge clk);
        d_hazard = 1'b0;
        uart_busy = 1'b1;
        repeat (weff + u + 1) @(negedge clk);
        uart_busy = 1'b0;
    endtask

    task automatic run_random(input int n, input bit stop_last);
        int w;
        for (int i = 0; i < n; i++) begin
            w = ($urandom_range(0, 5) == 0) ? 31 : int'($urandom_range(0, 12));
            run_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      stop_last && (i == n - 1), $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        bit ok;
        logic [31:0] pc_hold;
        rstn = 1'b0;
        aa_recieved = 0; load_done = 0; aa_sent = 0; d_npc = 0; d_hazard = 0;
        de_wait_time = 0; de_stop = 0; uart_busy = 0;
        n_ret = 0; sum_cyc = 0; last_pc = PC_RST - 32'd1;
        repeat (3) @(negedge clk);
        chk("rst_mode", mode, 3'd0);
        chk("rst_pipe", pipe, 3'd0);
        chk("rst_pc", pc, PC_RST);
        chk("rst_flags", {e_start, halted, fd_update, de_update, ew_update}, 0);
        chk("rst_retired", retired, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        boot();

        // Straight-line, then latency, clamp and stall cases, then random
        for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 1'b0, 1'b1);
        run_instr(5, 0, 0, 1'b0, 1'b1);
        run_instr(31, 0, 0, 1'b0, 1'b0);
        run_instr(0, 2, 3, 1'b0, 1'b1);
        run_random(14, 1'b0);

        // Abandon an instruction mid-EXECUTE with an asynchronous reset
        wait_decode(ok);
        d_npc = 32'hDEAD_BEEF; de_wait_time = 5'd8; d_hazard = 0; uart_busy = 0; de_stop = 0;
        repeat (3) @(negedge clk);
        chk("pre_rst_pipe_execute", pipe, 3'd2);
        chk("pre_rst_retired", retired, perf(n_ret));
        chk("pending_before_rst", q.size(), 0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_mode", mode, 3'd0);
        chk("arst_pipe", pipe, 3'd0);
        chk("arst_pc", pc, PC_RST);
        chk("arst_strobes", {e_start, halted, fd_update, de_update, ew_update}, 0);
        chk("arst_counters", retired | exec_cycles, 32'd0);
        q.delete();
        n_ret = 0; sum_cyc = 0; last_pc = PC_RST - 32'd1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        boot();
        run_random(12, 1'b1);

        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pipe == 3'd4) begin ok = 1'b1; break; end
        end
        chk("halt_reached", ok, 1'b1);
        chk("halt_mode", mode, 3'd3);
        chk("halt_flag", halted, 1'b1);
        chk("halt_pc", pc, last_pc);
        chk("halt_retired", retired, perf(n_ret));
        chk("halt_exec_cycles", exec_cycles, perf(sum_cyc));
        pc_hold = pc;
        d_npc = ~pc_hold; d_hazard = 1'b0;
        repeat (6) @(negedge clk);
        chk("halt_sticky_mode", {mode, pipe}, {3'd3, 3'd4});
        chk("halt_pc_frozen", pc, pc_hold);
        chk("halt_updates", {fd_update, de_update, ew_update, e_start}, 0);
        chk("halt_exec_stopped", exec_cycles, perf(sum_cyc));
        chk("pending_end", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
        $fatal(1);
    end

endmodule
